// File: rtl/des_sbox_bank.sv
// Bank of runtime-loadable DES S-boxes: register-file tables, a write/load counter,
// and one registered valid/ready output stage (48 -> 32 bits per lookup).
module des_sbox_bank #(
    parameter int NUM_BOX = 8,
    parameter int BOX_IN  = 6,
    parameter int BOX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [2:0]                   wr_box,
    input  logic [BOX_IN-1:0]            wr_addr,
    input  logic [BOX_OUT-1:0]           wr_data,
    output logic                         loaded,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:NUM_BOX*BOX_IN]      in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:NUM_BOX*BOX_OUT]     out_data
);

    localparam int DEPTH = 2 ** BOX_IN;
    localparam int TOTAL = NUM_BOX * DEPTH;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);
    localparam logic [3:0] NUM_BOX_W = 4'(NUM_BOX);

    logic [CNT_W-1:0]            load_cnt_q, load_cnt_d;
    logic                        loaded_q, loaded_d;
    logic                        out_valid_q, out_valid_d;
    logic [1:NUM_BOX*BOX_OUT]    out_data_q, out_data_d;
    logic [1:NUM_BOX*BOX_OUT]    rd_all;
    logic                        wr_valid;
    logic                        accept;

    assign wr_valid = wr_en && ({1'b0, wr_box} < NUM_BOX_W);
    assign in_ready = loaded_q & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BOX; gi++) begin : g_box
            logic [BOX_OUT-1:0] mem_q [DEPTH];
            logic [1:BOX_IN]    a;
            logic [BOX_IN-1:0]  idx;

            // Table contents are deliberately left unreset; the host reloads them.
            always_ff @(posedge clk) begin
                if (wr_en && (wr_box == 3'(gi))) begin
                    mem_q[wr_addr] <= wr_data;
                end
            end

            // Outer bits pick the row, inner bits the column: index = row*16 + col.
            assign a   = in_data[gi*BOX_IN+1 +: BOX_IN];
            assign idx = {a[1], a[BOX_IN], a[2:BOX_IN-1]};
            assign rd_all[gi*BOX_OUT+1 +: BOX_OUT] = mem_q[idx];
        end
    endgenerate

    always_comb begin
        load_cnt_d  = load_cnt_q;
        loaded_d    = loaded_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (wr_valid && !loaded_q) begin
            load_cnt_d = load_cnt_q + CNT_W'(1);
            if (load_cnt_q == CNT_LAST) begin
                loaded_d = 1'b1;
            end
        end

        // A same-edge table write lands after this read, so lookups see the old entry.
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_all;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_q  <= '0;
            loaded_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            loaded_q    <= loaded_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign loaded    = loaded_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: doc/des_sbox_bank.md
# des_sbox_bank

Runtime-loadable, pipelined bank of DES substitution boxes with a valid/ready stream interface. Replaces per-box `$readmemh` ROMs with register-file tables, so the design synthesises without init files and the tables can be reloaded in system. The block sits between the expansion/key-XOR stage and the P-permutation in the DES round datapath. It maps 48 bits to 32 bits at one lookup per cycle, with a single registered output stage.

## Interface
Parameters:
- `NUM_BOX`, default 8: number of S-boxes in the bank (1..8).
- `BOX_IN`, default 6: input bits per box; the table holds 2**BOX_IN entries.
- `BOX_OUT`, default 4: output bits per box.

Ports, with bit 1 as the MSB on all data buses:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_en`  in  1  table write strobe.
- `wr_box`  in  3  index of the target box, 0..NUM_BOX-1.
- `wr_addr`  in  BOX_IN  physical table index, equal to row*16+col.
- `wr_data`  in  BOX_OUT  entry value.
- `loaded`  out  1  high once NUM_BOX*2**BOX_IN writes have been accepted.
- `in_valid`  in  1  lookup request.
- `in_ready`  out  1  lookup accepted this cycle when high together with `in_valid`.
- `in_data`  in  [1:NUM_BOX*BOX_IN]  box k occupies bits 6k+1..6k+6, with k=0 as the leftmost box.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts `out_data`.
- `out_data`  out  [1:NUM_BOX*BOX_OUT]  box k result occupies bits 4k+1..4k+4.

## Operation
- Storage is NUM_BOX × 2**BOX_IN × BOX_OUT flops. Table contents are not reset; they are undefined until written.
- Write port:
  - When `wr_en`=1, the entry at [`wr_box`][`wr_addr`] takes `wr_data` at the clock edge.
  - A write with `wr_box`≥NUM_BOX is ignored and is not counted.
- Load counter:
  - `load_cnt` counts valid writes while `loaded`=0.
  - When the count reaches NUM_BOX*2**BOX_IN, `loaded` sets and the counter freezes.
  - Writes after `loaded`=1 still update the table but do not change `loaded`.
  - No check is made for duplicate addresses. The host must write every entry exactly once during load.
- Address remap per box:
  - For box input a[1:6], the physical index is {a[1],a[6],a[2:5]}: the outer bits select the row, the inner bits select the column.
  - For general BOX_IN, the index is {a[1],a[BOX_IN],a[2:BOX_IN-1]}.
- Lookup:
  - `in_ready` = `loaded` & (~`out_valid` | `out_ready`).
  - On accept (`in_valid` & `in_ready`), all boxes read in parallel and `out_data` registers the results; `out_valid` sets.
  - `in_valid` while `loaded`=0 is never accepted.
- Output:
  - `out_valid` clears when `out_ready`=1 and no new accept occurs in the same cycle.
  - While `out_valid`=1 and `out_ready`=0, `out_data` holds stable.
- Same-cycle write and lookup to the same entry: the lookup returns the pre-write (old) value. The new value is visible to the next accepted lookup.
- Reset may assert at any time, including mid-stream or mid-load:
  - `out_valid`=0, `out_data`=0, `loaded`=0 and `load_cnt`=0 immediately.
  - The table must be fully reloaded after reset.

## Timing
- Lookup latency is 1 cycle, from accept edge to `out_valid`/`out_data`.
- Throughput is 1 lookup per cycle while `out_ready`=1.
- Backpressure has zero bubble: when `out_valid`=1 and `out_ready`=1, a new accept in the same cycle replaces the data and `out_valid` stays 1.
- `loaded` rises on the edge that registers the final counted write. The first lookup can be accepted in the following cycle.
- Reset values of outputs: `in_ready`=0, `loaded`=0, `out_valid`=0, `out_data`=0.
- The critical path is the in_data remap, a 64:1 mux per box, and then the output register. No combinational path runs from `in_data` to `out_data`.

## Test plan
- **Load and zero input:** write the standard DES S1..S8 tables (512 writes), then send `in_data`=48'h0 → after 1 cycle, `out_data`=32'hEFA72C4D with `out_valid`=1; `loaded` rises exactly after write 512.
- **Remap check:** send S1 input 6'b011011 with all other boxes 0 → box 0 output = 4'h5 (row 1, col 13).
- **Not-loaded gating:** assert `in_valid` before `loaded` (after only 511 writes) → `in_ready`=0 and `out_valid` stays 0. After write 512, the request is accepted on the next cycle.
- **Backpressure:** stream 4 random vectors with `out_ready` toggling 1,0,0,1 → each result holds while stalled, no vector is lost or duplicated, and every result matches the software DES S-box model.
- **Same-cycle collision:** rewrite S1 row 0 col 0 from 14 to 3 in the same cycle as a lookup of 48'h0 → first output nibble = 4'hE. A second lookup returns 4'h3.
- **Reset mid-stream:** pulse `rst_n` low while `out_valid`=1 → `out_valid`, `out_data` and `loaded` are 0 immediately. Lookups are rejected until a full 512-write reload completes.
